// File: rtl/llc_set_conflict_table.sv
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif
// Tracks in-flight LLC sets; lookup/alloc_ready are same-cycle, wake/release_err register 1 cycle after release.
// Allocation backpressures through alloc_ready (full, clear, or duplicate set when ALLOW_DUP=0).
module llc_set_conflict_table #(
  parameter int DEPTH     = 5,
  parameter int SET_BITS  = `LLC_SET_BITS,
  parameter bit ALLOW_DUP = 1'b0,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                alloc_valid,
  input  logic [SET_BITS-1:0] alloc_set,
  output logic                alloc_ready,
  output logic [IDX_W-1:0]    alloc_idx,
  input  logic [SET_BITS-1:0] lookup_set,
  output logic                lookup_hit,
  output logic [IDX_W-1:0]    lookup_idx,
  input  logic                release_valid,
  input  logic [IDX_W-1:0]    release_idx,
  output logic                wake_valid,
  output logic [SET_BITS-1:0] wake_set,
  output logic                release_err,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  logic [DEPTH-1:0]    valid;
  logic [SET_BITS-1:0] set_q [DEPTH];
  logic                dup;
  logic                a_fire;
  logic                r_fire;
  logic                r_bad;
  logic                r_slot_vld;
  logic [SET_BITS-1:0] r_slot_set;

  // Descending scan so the lowest matching/free slot wins.
  always_comb begin
    alloc_idx  = '0;
    dup        = 1'b0;
    lookup_hit = 1'b0;
    lookup_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IDX_W'(i);
      if (valid[i] && set_q[i] == lookup_set) begin
        lookup_hit = 1'b1;
        lookup_idx = IDX_W'(i);
      end
      if (valid[i] && set_q[i] == alloc_set) dup = 1'b1;
    end
  end

  // An out-of-range release_idx matches no slot and so reads as not valid.
  always_comb begin
    r_slot_vld = 1'b0;
    r_slot_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (release_idx == IDX_W'(i)) begin
        r_slot_vld = valid[i];
        r_slot_set = set_q[i];
      end
    end
  end

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign alloc_ready = !full && !clr && (ALLOW_DUP || !dup);
  assign a_fire      = alloc_valid && alloc_ready;
  assign r_fire      = release_valid && !clr && r_slot_vld;
  assign r_bad       = release_valid && !clr && !r_slot_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= '0;
      count       <= '0;
      wake_valid  <= 1'b0;
      wake_set    <= '0;
      release_err <= 1'b0;
    end else if (clr) begin
      valid       <= '0;
      count       <= '0;
      wake_valid  <= 1'b0;
      release_err <= 1'b0;
    end else begin
      wake_valid  <= r_fire;
      release_err <= r_bad;
      if (r_fire) wake_set <= r_slot_set;
      // alloc_idx is always a free slot, so it never collides with a firing release.
      for (int i = 0; i < DEPTH; i++) begin
        if (a_fire && alloc_idx == IDX_W'(i)) valid[i] <= 1'b1;
        else if (r_fire && release_idx == IDX_W'(i)) valid[i] <= 1'b0;
      end
      case ({a_fire, r_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set payload needs no reset; it is qualified by valid everywhere.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (a_fire && alloc_idx == IDX_W'(i)) set_q[i] <= alloc_set;
    end
  end

endmodule

// File: tb/tb_llc_set_conflict_table.sv
// Directed checks of the set conflict table (DEPTH=5, no duplicates) plus a DEPTH=8 duplicate/soak instance.
module tb_llc_set_conflict_table;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DEPTH=5, ALLOW_DUP=0
  logic       clr = 1'b0, alloc_valid = 1'b0, release_valid = 1'b0;
  logic [7:0] alloc_set = '0, lookup_set = '0;
  logic [2:0] release_idx = '0;
  logic       alloc_ready, lookup_hit, wake_valid, release_err, full, empty;
  logic [2:0] alloc_idx, lookup_idx, count;
  logic [7:0] wake_set;

  // DEPTH=8, ALLOW_DUP=1
  logic       d8_clr = 1'b0, d8_alloc_valid = 1'b0, d8_release_valid = 1'b0;
  logic [7:0] d8_alloc_set = '0, d8_lookup_set = '0;
  logic [2:0] d8_release_idx = '0;
  logic       d8_alloc_ready, d8_lookup_hit, d8_wake_valid, d8_release_err, d8_full, d8_empty;
  logic [2:0] d8_alloc_idx, d8_lookup_idx;
  logic [3:0] d8_count;
  logic [7:0] d8_wake_set;

  llc_set_conflict_table #(.DEPTH(5), .SET_BITS(8), .ALLOW_DUP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .alloc_valid(alloc_valid), .alloc_set(alloc_set), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .lookup_set(lookup_set), .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
    .release_valid(release_valid), .release_idx(release_idx),
    .wake_valid(wake_valid), .wake_set(wake_set), .release_err(release_err),
    .count(count), .full(full), .empty(empty)
  );

  llc_set_conflict_table #(.DEPTH(8), .SET_BITS(8), .ALLOW_DUP(1'b1)) u_d8 (
    .clk(clk), .rst(rst), .clr(d8_clr),
    .alloc_valid(d8_alloc_valid), .alloc_set(d8_alloc_set), .alloc_ready(d8_alloc_ready), .alloc_idx(d8_alloc_idx),
    .lookup_set(d8_lookup_set), .lookup_hit(d8_lookup_hit), .lookup_idx(d8_lookup_idx),
    .release_valid(d8_release_valid), .release_idx(d8_release_idx),
    .wake_valid(d8_wake_valid), .wake_set(d8_wake_set), .release_err(d8_release_err),
    .count(d8_count), .full(d8_full), .empty(d8_empty)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_ready"}, 32'(alloc_ready), 1);
    check({tag, "_wake_valid"}, 32'(wake_valid), 0);
    check({tag, "_wake_set"}, 32'(wake_set), 0);
    check({tag, "_release_err"}, 32'(release_err), 0);
  endtask

  // Soak reference model for the DEPTH=8 instance
  logic [7:0] m_valid;
  logic [7:0] m_set [8];

  initial begin
    #2;
    check_reset_outputs("reset");
    check("reset_d8_empty", 32'(d8_empty), 1);
    #10 rst = 1'b1;
    tick();

    // 1. Fill: slots 0..4 in order, then full and refusing
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      alloc_set   = 8'h10 + 8'(i);
      #1;
      check("fill_idx", 32'(alloc_idx), 32'(i));
      check("fill_ready", 32'(alloc_ready), 1);
      tick();
    end
    alloc_set  = 8'h15;
    lookup_set = 8'h13;
    #1;
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 5);
    check("fill_6th_ready", 32'(alloc_ready), 0);
    check("fill_lookup_hit", 32'(lookup_hit), 1);
    check("fill_lookup_idx", 32'(lookup_idx), 3);
    alloc_valid = 1'b0;

    // 2. Release 2 then 0; wake follows; lowest free slot is reused first
    release_valid = 1'b1;
    release_idx   = 3'd2;
    tick();
    release_idx = 3'd0;
    #1;
    check("rel2_wake_valid", 32'(wake_valid), 1);
    check("rel2_wake_set", 32'(wake_set), 32'h12);
    tick();
    release_valid = 1'b0;
    #1;
    check("rel0_wake_set", 32'(wake_set), 32'h10);
    check("rel0_count", 32'(count), 3);
    alloc_valid = 1'b1;
    alloc_set   = 8'h20;
    #1;
    check("realloc_idx0", 32'(alloc_idx), 0);
    tick();
    alloc_set = 8'h21;
    #1;
    check("realloc_idx2", 32'(alloc_idx), 2);
    check("wake_drop", 32'(wake_valid), 0);
    check("wake_set_hold", 32'(wake_set), 32'h10);
    tick();
    alloc_valid = 1'b0;
    // table: 20 11 21 13 14

    // 4. Full table with same-cycle alloc + release of slot 3
    alloc_valid   = 1'b1;
    alloc_set     = 8'h40;
    release_valid = 1'b1;
    release_idx   = 3'd3;
    #1;
    check("simul_ready", 32'(alloc_ready), 0);
    tick();
    release_valid = 1'b0;
    #1;
    check("simul_count", 32'(count), 4);
    check("simul_wake_set", 32'(wake_set), 32'h13);
    check("simul_next_ready", 32'(alloc_ready), 1);
    check("simul_next_idx", 32'(alloc_idx), 3);
    tick();
    alloc_valid = 1'b0;
    lookup_set  = 8'h40;
    #1;
    check("simul_count5", 32'(count), 5);
    check("simul_lookup_idx", 32'(lookup_idx), 3);
    // table: 20 11 21 40 14

    // 3. Duplicate blocking
    release_valid = 1'b1;
    release_idx   = 3'd4;
    tick();
    release_idx = 3'd1;
    tick();
    release_valid = 1'b0;
    alloc_valid   = 1'b1;
    alloc_set     = 8'h33;
    #1;
    check("dup_first_idx", 32'(alloc_idx), 1);
    tick();
    lookup_set = 8'h33;
    #1;
    check("dup_ready", 32'(alloc_ready), 0);
    check("dup_lookup_hit", 32'(lookup_hit), 1);
    check("dup_lookup_idx", 32'(lookup_idx), 1);
    release_valid = 1'b1;
    release_idx   = 3'd1;
    #1;
    check("dup_rel_ready", 32'(alloc_ready), 0);
    check("dup_rel_still_hit", 32'(lookup_hit), 1);
    tick();
    release_valid = 1'b0;
    #1;
    check("dup_wake_valid", 32'(wake_valid), 1);
    check("dup_wake_set", 32'(wake_set), 32'h33);
    check("dup_after_ready", 32'(alloc_ready), 1);
    check("dup_after_idx", 32'(alloc_idx), 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("dup_count", 32'(count), 4);
    check("dup_relookup", 32'(lookup_hit), 1);
    // table: 20 33 21 40 --

    // 5. Bad releases then clear
    release_valid = 1'b1;
    release_idx   = 3'd4;
    tick();
    release_idx = 3'd6;
    #1;
    check("err_empty_slot", 32'(release_err), 1);
    check("err_no_wake", 32'(wake_valid), 0);
    check("err_count", 32'(count), 4);
    tick();
    release_valid = 1'b0;
    #1;
    check("err_out_of_range", 32'(release_err), 1);
    tick();
    check("err_drop", 32'(release_err), 0);
    release_valid = 1'b1;
    release_idx   = 3'd0;
    tick();
    clr         = 1'b1;
    release_idx = 3'd1;
    alloc_valid = 1'b1;
    alloc_set   = 8'h77;
    #1;
    check("clr_pre_count", 32'(count), 3);
    check("clr_ready", 32'(alloc_ready), 0);
    tick();
    clr           = 1'b0;
    release_valid = 1'b0;
    alloc_valid   = 1'b0;
    #1;
    check("clr_count", 32'(count), 0);
    check("clr_empty", 32'(empty), 1);
    check("clr_no_wake", 32'(wake_valid), 0);
    check("clr_lookup", 32'(lookup_hit), 0);

    // 6. Asynchronous reset mid-operation
    alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alloc_set = 8'h50 + 8'(i);
      tick();
    end
    alloc_valid   = 1'b0;
    release_valid = 1'b1;
    release_idx   = 3'd0;
    tick();
    release_valid = 1'b0;
    lookup_set    = 8'h51;
    #1;
    check("prerst_count", 32'(count), 4);
    check("prerst_wake", 32'(wake_valid), 1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_lookup", 32'(lookup_hit), 0);
    tick();
    rst = 1'b1;
    tick();

    // DEPTH=8 with duplicates allowed
    d8_alloc_valid = 1'b1;
    d8_alloc_set   = 8'h33;
    tick();
    #1;
    check("d8_dup_ready", 32'(d8_alloc_ready), 1);
    check("d8_dup_idx", 32'(d8_alloc_idx), 1);
    tick();
    d8_alloc_valid = 1'b0;
    #1;
    check("d8_dup_count", 32'(d8_count), 2);

    // Random soak against a reference table
    m_valid = 8'b0000_0011;
    m_set[0] = 8'h33;
    m_set[1] = 8'h33;
    for (int i = 2; i < 8; i++) m_set[i] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic       exp_ready, a_f, r_f;
      logic [2:0] exp_idx;
      d8_alloc_valid   = 1'($urandom_range(0, 1));
      d8_alloc_set     = 8'($urandom_range(0, 7));
      d8_release_valid = 1'($urandom_range(0, 1));
      d8_release_idx   = 3'($urandom_range(0, 7));
      d8_clr           = ($urandom_range(0, 39) == 0);
      d8_lookup_set    = 8'($urandom_range(0, 7));
      exp_idx = '0;
      for (int s = 7; s >= 0; s--) if (!m_valid[s]) exp_idx = 3'(s);
      exp_ready = (m_valid != 8'hff) && !d8_clr;
      #1;
      check("soak_ready", 32'(d8_alloc_ready), 32'(exp_ready));
      if (m_valid != 8'hff) check("soak_idx", 32'(d8_alloc_idx), 32'(exp_idx));
      a_f = d8_alloc_valid && exp_ready;
      r_f = d8_release_valid && !d8_clr && m_valid[d8_release_idx];
      if (d8_clr) m_valid = '0;
      else begin
        if (a_f) begin
          m_valid[exp_idx] = 1'b1;
          m_set[exp_idx]   = d8_alloc_set;
        end
        if (r_f) m_valid[d8_release_idx] = 1'b0;
      end
      tick();
      check("soak_count", 32'(d8_count), 32'($countones(m_valid)));
      check("soak_wake", 32'(d8_wake_valid), 32'(r_f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
